// File: rtl/cnn_image_loader.sv
// Purpose: write side of the CNN pixel RAM; loads one frame row-major, then starts and re-arms the engine.
// Latency: a pixel accepted on cycle T is written on cycle T+1; eng_start follows the final write by one cycle.
// Backpressure: s_ready is high only in RECV and DROP; no beats are taken from START through ENG_CLR.
// Option: define LOADER_ZERO_PAD_EN to zero-pad short frames instead of discarding them.
module cnn_image_loader #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              eng_start,
  input  logic              eng_done,
  output logic              eng_rst,
  output logic              busy,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int N = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(N - 1);

  typedef enum logic [2:0] {RECV, PAD, DROP, START, WAIT_DONE, ENG_CLR} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               eng_start_q, eng_start_d;
  logic               eng_rst_q, eng_rst_d;
  logic               busy_q, busy_d;
  logic               frame_err_q, frame_err_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               beat;

  // Ready is decoded straight from the registered state so the source sees it without a cycle of lag.
  assign s_ready = (state_q == RECV) || (state_q == DROP);
  assign beat    = s_valid && s_ready;

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    eng_start_d = 1'b0;
    eng_rst_d   = 1'b0;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      RECV: begin
        if (beat) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = pix_cnt_q;
          mem_wdata_d = s_data;
          if (pix_cnt_q == LAST_PIX) begin
            // Final slot filled: either a clean end or the start of an overlong tail.
            state_d = s_last ? START : DROP;
          end else if (s_last) begin
            frame_err_d = 1'b1;
`ifdef LOADER_ZERO_PAD_EN
            pix_cnt_d = pix_cnt_q + 1'b1;
            state_d   = PAD;
`else
            // Partial data stays in RAM; the next good frame overwrites every address.
            pix_cnt_d = '0;
`endif
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      PAD: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = pix_cnt_q;
        mem_wdata_d = '0;
        if (pix_cnt_q == LAST_PIX) state_d = START;
        else                       pix_cnt_d = pix_cnt_q + 1'b1;
      end
      DROP: begin
        if (beat && s_last) begin
          frame_err_d = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        eng_start_d = 1'b1;
        state_d     = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (eng_done) state_d = ENG_CLR;
      end
      ENG_CLR: begin
        eng_rst_d   = 1'b1;
        frame_cnt_d = frame_cnt_q + 1'b1;
        pix_cnt_d   = '0;
        state_d     = RECV;
      end
      default: state_d = RECV;
    endcase
    busy_d = (state_d != RECV);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RECV;
      pix_cnt_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      eng_start_q <= 1'b0;
      eng_rst_q   <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      eng_start_q <= eng_start_d;
      eng_rst_q   <= eng_rst_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign eng_start = eng_start_q;
  assign eng_rst   = eng_rst_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_cnn_image_loader.sv
// Bench for cnn_image_loader: random frames against a frame-level model of the RAM image and pulses.
// Latency expectations: eng_start one cycle after the final write (or after frame_err for long frames).
// Engine side is emulated here: eng_done rises after a random delay and drops after eng_rst.
module tb_cnn_image_loader;
  localparam int N  = 64;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_last;
  logic [DW-1:0] s_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          eng_start, eng_done, eng_rst, busy, frame_err;
  logic [CW-1:0] frame_cnt;

  always #5 clk = ~clk;

  cnn_image_loader #(.IMG_W(8), .IMG_H(8), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .eng_start(eng_start), .eng_done(eng_done), .eng_rst(eng_rst),
    .busy(busy), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int exp_fc = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Output monitor: sampled on the falling edge, only this block writes these.
  logic [AW+DW-1:0] wq[$];
  int cyc = 0, start_cnt = 0, err_cnt = 0, erst_cnt = 0;
  int last_wr_cyc = 0, start_cyc = 0, err_cyc = 0, erst_cyc = 0;
  always @(negedge clk) begin
    if (mem_we)    begin wq.push_back({mem_addr, mem_wdata}); last_wr_cyc = cyc; end
    if (eng_start) begin start_cnt++; start_cyc = cyc; end
    if (frame_err) begin err_cnt++;   err_cyc   = cyc; end
    if (eng_rst)   begin erst_cnt++;  erst_cyc  = cyc; end
    cyc++;
  end

  // Push beats 0..nb-1 of d; valid asserted with probability vpct percent.
  task automatic drive_beats(input string nm, input logic [DW-1:0] d[$], input int nb,
                             input int last_at, input int vpct);
    int beats = 0;
    int guard = 0;
    while (beats < nb && guard < 5000) begin
      s_valid = ($urandom_range(99) < vpct);
      s_data  = s_valid ? d[beats] : DW'($urandom);
      s_last  = (beats == last_at);
      @(negedge clk);
      if (s_valid && s_ready) beats++;
      @(posedge clk); #1;
      guard++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (guard >= 5000) chk({nm, "_beats_timeout"}, beats, nb);
  endtask

  // One frame with s_last on beat last_at; model computes the expected RAM writes and pulses.
  task automatic run_frame(input string nm, input int last_at, input int vpct,
                           input bit seq_data, input bit done_early);
    logic [DW-1:0]    d[$];
    logic [AW+DW-1:0] exp_w[$];
    int wb, sb, eb, rb, k, nw;
    bit exp_start, exp_err;
    for (int i = 0; i <= last_at; i++) d.push_back(seq_data ? DW'(i) : DW'($urandom));
    exp_err = (last_at != N - 1);
    for (int i = 0; i <= last_at && i < N; i++) exp_w.push_back({AW'(i), d[i]});
`ifdef LOADER_ZERO_PAD_EN
    exp_start = 1'b1;
    for (int i = last_at + 1; i < N; i++) exp_w.push_back({AW'(i), DW'(0)});
`else
    exp_start = (last_at >= N - 1);
`endif
    wb = wq.size(); sb = start_cnt; eb = err_cnt; rb = erst_cnt;
    if (done_early) eng_done = 1'b1;
    drive_beats(nm, d, last_at + 1, last_at, vpct);
    if (exp_start) begin
      k = 0;
      while (start_cnt == sb && k < 300) begin @(posedge clk); k++; end
      chk({nm, "_start_cnt"}, start_cnt - sb, 1);
      if (last_at > N - 1) chk({nm, "_start_after_err"}, start_cyc, err_cyc + 1);
      else                 chk({nm, "_start_after_wr"}, start_cyc, last_wr_cyc + 1);
      chk({nm, "_erst_early"}, erst_cnt - rb, 0);
      if (!done_early) begin
        repeat ($urandom_range(10, 1)) @(posedge clk);
        #1 eng_done = 1'b1;
      end
      k = 0;
      while (erst_cnt == rb && k < 300) begin @(posedge clk); k++; end
      chk({nm, "_erst_cnt"}, erst_cnt - rb, 1);
      if (done_early) chk({nm, "_erst_lat"}, erst_cyc - start_cyc, 2);
      #1 eng_done = 1'b0;
      exp_fc = (exp_fc + 1) % (1 << CW);
      chk({nm, "_frame_cnt"}, frame_cnt, exp_fc);
      chk({nm, "_s_ready"}, s_ready, 1);
      chk({nm, "_busy"}, busy, 0);
    end else begin
      repeat (10) @(posedge clk);
      #1;
      chk({nm, "_no_start"}, start_cnt - sb, 0);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_frame_cnt"}, frame_cnt, exp_fc);
    end
    chk({nm, "_frame_err"}, err_cnt - eb, exp_err);
    nw = wq.size() - wb;
    chk({nm, "_nwrites"}, nw, exp_w.size());
    for (int i = 0; i < nw && i < exp_w.size(); i++) chk({nm, "_wr"}, wq[wb + i], exp_w[i]);
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_mem_we"}, mem_we, 0);
    chk({nm, "_mem_addr"}, mem_addr, 0);
    chk({nm, "_mem_wdata"}, mem_wdata, 0);
    chk({nm, "_eng_start"}, eng_start, 0);
    chk({nm, "_eng_rst"}, eng_rst, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_frame_err"}, frame_err, 0);
    chk({nm, "_frame_cnt"}, frame_cnt, 0);
    chk({nm, "_s_ready"}, s_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d[$];
    int sb, la;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; eng_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    run_frame("seq", N - 1, 100, 1'b1, 1'b0);
    run_frame("gaps", N - 1, 50, 1'b1, 1'b0);
    run_frame("short39", 39, 70, 1'b0, 1'b0);
    run_frame("after_short", N - 1, 80, 1'b0, 1'b0);
    run_frame("long70", 69, 100, 1'b0, 1'b0);
    run_frame("short62", N - 2, 60, 1'b0, 1'b0);
    run_frame("long65", N, 90, 1'b0, 1'b0);

    // Reset after 20 beats: everything clears, no start, then a clean frame from address 0.
    for (int i = 0; i < 20; i++) d.push_back(DW'($urandom));
    sb = start_cnt;
    drive_beats("rst20", d, 20, N - 1, 100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_fc = 0;
    check_idle("midrst");
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_start", start_cnt - sb, 0);
    run_frame("post_rst", N - 1, 100, 1'b0, 1'b0);

    run_frame("done_early", N - 1, 60, 1'b0, 1'b1);

    for (int r = 0; r < 4; r++) begin
      case ($urandom_range(2))
        0:       la = N - 1;
        1:       la = $urandom_range(N - 2);
        default: la = $urandom_range(N + 6, N);
      endcase
      run_frame("rand", la, $urandom_range(100, 30), 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
